// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control unit:
// state encoding, opcodes, datapath mux selects and the decode-target helper.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWRITE, MEMWB, EXECR, EXECI,
    ALUWB, BEQ, JAL, JALR, JALPC, JAL_LINK, UPPER, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Where DECODE dispatches each opcode; unknown opcodes land in TRAP.
  function automatic state_t decode_target(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: return MEMADR;
      OP_R:              return EXECR;
      OP_I:              return EXECI;
      OP_BRANCH:         return BEQ;
      OP_JAL:            return JAL;
      OP_JALR:           return JALR;
      OP_LUI, OP_AUIPC:  return UPPER;
      default:           return TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_imm_src_decode.sv
// Combinational opcode -> immediate-format select, kept separate so the
// pipelined decoder can reuse it.
module imm_src_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W      = 7,
  parameter int IMM_SRC_W = 3
) (
  input  logic [OP_W-1:0]      i_opcode,
  output logic [IMM_SRC_W-1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_SRC_W'(IMM_I);
    case (i_opcode)
      OP_STORE:         o_imm_src = IMM_SRC_W'(IMM_S);
      OP_BRANCH:        o_imm_src = IMM_SRC_W'(IMM_B);
      OP_JAL:           o_imm_src = IMM_SRC_W'(IMM_J);
      OP_LUI, OP_AUIPC: o_imm_src = IMM_SRC_W'(IMM_U);
      default:          o_imm_src = IMM_SRC_W'(IMM_I);
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM with a cache valid/ready handshake, a memory
// watchdog and a sticky TRAP state for illegal opcodes and timeouts.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W        = 7,
  parameter int IMM_SRC_W   = 3,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [OP_W-1:0]      i_opcode,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_mem_write,
  output logic                 o_adr_src,
  output logic                 o_ir_write,
  output logic                 o_pc_write,
  output logic                 o_branch,
  output logic                 o_reg_write,
  output logic [1:0]           o_alu_src_a,
  output logic [1:0]           o_alu_src_b,
  output logic [1:0]           o_alu_op,
  output logic [1:0]           o_result_src,
  output logic [IMM_SRC_W-1:0] o_imm_src,
  output logic                 o_illegal_op,
  output logic                 o_mem_timeout,
  output logic [3:0]           o_state_dbg
);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_wd_cnt;
  logic               r_illegal;
  logic               r_timeout;
  logic               w_expire;
  logic               w_set_illegal;

  // The watchdog only fires while a request is actually stalled; a
  // same-cycle mem_ready always completes the access instead.
  assign w_expire = (TIMEOUT_CYC != 0) && o_mem_req && !i_mem_ready &&
                    (r_wd_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= FETCH;
      r_wd_cnt  <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_expire)      r_timeout <= 1'b1;
      if ((w_next != r_state) || i_mem_ready || !o_mem_req)
        r_wd_cnt <= '0;
      else if (r_wd_cnt != '1)
        r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_write   = 1'b0;
    o_adr_src     = 1'b0;
    o_ir_write    = 1'b0;
    o_pc_write    = 1'b0;
    o_branch      = 1'b0;
    o_reg_write   = 1'b0;
    o_alu_src_a   = SRCA_PC;
    o_alu_src_b   = SRCB_RS2;
    o_alu_op      = ALUOP_ADD;
    o_result_src  = RES_ALUOUT;
    case (r_state)
      FETCH: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = DECODE;
        end
      end
      DECODE: begin
        o_alu_src_a   = SRCA_OLDPC;
        o_alu_src_b   = SRCB_IMM;
        w_next        = decode_target(i_opcode);
        w_set_illegal = (w_next == TRAP);
      end
      MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        w_next      = (i_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        o_mem_req = 1'b1;
        o_adr_src = 1'b1;
        if (i_mem_ready) w_next = MEMWB;
      end
      MEMWRITE: begin
        o_mem_req   = 1'b1;
        o_mem_write = 1'b1;
        o_adr_src   = 1'b1;
        if (i_mem_ready) w_next = FETCH;
      end
      MEMWB: begin
        o_result_src = RES_MEMDATA;
        o_reg_write  = 1'b1;
        w_next       = FETCH;
      end
      EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_FUNCT;
        w_next      = ALUWB;
      end
      EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_FUNCT;
        w_next      = ALUWB;
      end
      ALUWB: begin
        o_reg_write = 1'b1;
        w_next      = FETCH;
      end
      BEQ: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_SUB;
        o_branch    = 1'b1;
        w_next      = FETCH;
      end
      // PC takes the target already in ALUOut while the ALU forms OldPC+4.
      JAL: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_FOUR;
        o_pc_write  = 1'b1;
        w_next      = ALUWB;
      end
      JALR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        w_next      = JALPC;
      end
      JALPC: begin
        o_result_src = RES_ALURESULT;
        o_pc_write   = 1'b1;
        w_next       = JAL_LINK;
      end
      JAL_LINK: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_FOUR;
        w_next      = ALUWB;
      end
      UPPER: begin
        o_alu_src_a = (i_opcode == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
        w_next      = ALUWB;
      end
      TRAP: w_next = TRAP;
      default: w_next = TRAP;
    endcase
    if (w_expire) w_next = TRAP;
  end

  imm_src_decode #(
    .OP_W      (OP_W),
    .IMM_SRC_W (IMM_SRC_W)
  ) u_imm_src_decode (
    .i_opcode  (i_opcode),
    .o_imm_src (o_imm_src)
  );

  assign o_illegal_op  = r_illegal;
  assign o_mem_timeout = r_timeout;
  assign o_state_dbg   = r_state;

endmodule
